// File: rtl/bna_pkg.sv
// Shared definitions for the activation writer block.
//   LANES_PER_WORD : activations packed into one buffer word
//   LANE_IDX_W     : width of a lane-within-word index
//   aw_state_e     : writer FSM state encoding
package bna_pkg;

   localparam int LANES_PER_WORD = 4;
   localparam int LANE_IDX_W     = $clog2(LANES_PER_WORD);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } aw_state_e;

endpackage

// File: rtl/act_requant.sv
// act_requant: combinational requantizer for one accumulator lane.
//   acc   : signed MAC accumulator value
//   shift : right-shift amount (round half up when shift > 0)
//   q     : signed DATA_WIDTH result, saturated
// Optional macro ACT_WRITER_RELU_EN: negative results are clamped to 0.
module act_requant #(
   parameter int DATA_WIDTH    = 7,
   parameter int MAC_ACC_WIDTH = 48,
   parameter int SHIFT_WIDTH   = 6
) (
   input  logic [MAC_ACC_WIDTH-1:0] acc,
   input  logic [SHIFT_WIDTH-1:0]   shift,
   output logic [DATA_WIDTH-1:0]    q
);

   // One guard bit so acc + 2^(shift-1) cannot overflow.
   localparam int W = MAC_ACC_WIDTH + 1;
   localparam logic signed [W-1:0] Q_MAX = (W'(1) <<< (DATA_WIDTH-1)) - W'(1);
   localparam logic signed [W-1:0] Q_MIN = ~Q_MAX;

   logic signed [W-1:0] ext, rnd, shifted;
   logic                big_shift;

   always_comb begin
      ext = {acc[MAC_ACC_WIDTH-1], acc};
      rnd = '0;
      if (shift != '0) rnd = W'(1) << (shift - SHIFT_WIDTH'(1));
      shifted = (ext + rnd) >>> shift;
      // Beyond the guard width the rounding term no longer fits, but the exact
      // answer for any in-range accumulator is 0 there anyway.
      big_shift = int'(shift) > MAC_ACC_WIDTH;

      if (big_shift)             q = '0;
      else if (shifted > Q_MAX)  q = Q_MAX[DATA_WIDTH-1:0];
      else if (shifted < Q_MIN)  q = Q_MIN[DATA_WIDTH-1:0];
      else                       q = shifted[DATA_WIDTH-1:0];
`ifdef ACT_WRITER_RELU_EN
      if (q[DATA_WIDTH-1]) q = '0;
`endif
   end

endmodule

// File: rtl/activation_writer.sv
// activation_writer: requantizes a stream of accumulator values and packs
// them four per word into the activation buffer.
//   start_i/base_addr_i/num_lanes_i/shift_i : job setup, sampled in IDLE
//   acc_valid_i/acc_ready_o/acc_data_i      : accumulator stream
//   buffer_wr_en_o/_addr_o/buffer_data_o    : buffer RAM write port
//   busy_o, done_o                          : job status
// Pipeline: accept -> stage 1 (requant register) -> stage 2 (pack/output).
// Optional macro ACT_WRITER_RELU_EN (handled in act_requant).
module activation_writer
   import bna_pkg::*;
#(
   parameter int DATA_WIDTH        = 7,
   parameter int MAC_ACC_WIDTH     = 48,
   parameter int BUFFER_ADDR_WIDTH = 15,
   parameter int SHIFT_WIDTH       = 6
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              start_i,
   input  logic [BUFFER_ADDR_WIDTH-1:0]      base_addr_i,
   input  logic [BUFFER_ADDR_WIDTH+1:0]      num_lanes_i,
   input  logic [SHIFT_WIDTH-1:0]            shift_i,
   input  logic                              acc_valid_i,
   output logic                              acc_ready_o,
   input  logic [MAC_ACC_WIDTH-1:0]          acc_data_i,
   output logic                              buffer_wr_en_o,
   output logic [BUFFER_ADDR_WIDTH-1:0]      buffer_wr_addr_o,
   output logic [DATA_WIDTH*LANES_PER_WORD-1:0] buffer_data_o,
   output logic                              busy_o,
   output logic                              done_o
);

   localparam int NL_W   = BUFFER_ADDR_WIDTH + 2;
   localparam int STAGES = 2;

   aw_state_e                                  state;
   logic [BUFFER_ADDR_WIDTH-1:0]               wr_ptr;
   logic [NL_W-1:0]                            num_q, lane_cnt;
   logic [SHIFT_WIDTH-1:0]                     shift_q;
   logic [LANE_IDX_W-1:0]                      lane_idx, s1_idx;
   logic [DATA_WIDTH-1:0]                      rq, s1_data;
   logic                                       s1_flush;
   logic [STAGES:1]                            vld_pipe, last_pipe;
   logic [LANES_PER_WORD-1:0][DATA_WIDTH-1:0]  word_buf, new_word, data_q;
   logic                                       accept, is_last;

   assign accept        = acc_valid_i & acc_ready_o;
   assign is_last       = (lane_cnt == num_q - NL_W'(1));
   assign buffer_data_o = data_q;

   act_requant #(
      .DATA_WIDTH   (DATA_WIDTH),
      .MAC_ACC_WIDTH(MAC_ACC_WIDTH),
      .SHIFT_WIDTH  (SHIFT_WIDTH)
   ) u_requant (
      .acc  (acc_data_i),
      .shift(shift_q),
      .q    (rq)
   );

   // Partial word is kept zeroed above the lanes written so far, so a short
   // final word is zero-filled without extra masking.
   always_comb begin
      new_word         = word_buf;
      new_word[s1_idx] = s1_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= ST_IDLE;
         wr_ptr           <= '0;
         num_q            <= '0;
         lane_cnt         <= '0;
         shift_q          <= '0;
         lane_idx         <= '0;
         s1_idx           <= '0;
         s1_data          <= '0;
         s1_flush         <= 1'b0;
         vld_pipe         <= '0;
         last_pipe        <= '0;
         word_buf         <= '0;
         data_q           <= '0;
         buffer_wr_addr_o <= '0;
         buffer_wr_en_o   <= 1'b0;
         acc_ready_o      <= 1'b0;
         busy_o           <= 1'b0;
         done_o           <= 1'b0;
      end else begin
         vld_pipe       <= {vld_pipe[STAGES-1:1], accept};
         last_pipe      <= {last_pipe[STAGES-1:1], accept & is_last};
         buffer_wr_en_o <= 1'b0;
         done_o         <= 1'b0;

         // stage 1: register the requantized lane and its word position
         if (accept) begin
            s1_data  <= rq;
            s1_idx   <= lane_idx;
            s1_flush <= is_last | (lane_idx == LANE_IDX_W'(LANES_PER_WORD-1));
            lane_idx <= lane_idx + LANE_IDX_W'(1);
            lane_cnt <= lane_cnt + NL_W'(1);
         end

         // stage 2: assemble word; emit it on the 4th or final lane
         if (vld_pipe[1]) begin
            if (s1_flush) begin
               data_q           <= new_word;
               word_buf         <= '0;
               buffer_wr_en_o   <= 1'b1;
               buffer_wr_addr_o <= wr_ptr;
               wr_ptr           <= wr_ptr + BUFFER_ADDR_WIDTH'(1);
            end else begin
               word_buf <= new_word;
            end
         end

         case (state)
            ST_IDLE: begin
               if (start_i) begin
                  num_q    <= num_lanes_i;
                  shift_q  <= shift_i;
                  wr_ptr   <= base_addr_i;
                  lane_cnt <= '0;
                  lane_idx <= '0;
                  busy_o   <= 1'b1;
                  if (num_lanes_i == '0) begin
                     done_o <= 1'b1;
                  end else begin
                     state       <= ST_RUN;
                     acc_ready_o <= 1'b1;
                  end
               end else if (done_o) begin
                  busy_o <= 1'b0;
               end
            end
            ST_RUN: begin
               if (accept && is_last) begin
                  state       <= ST_DRAIN;
                  acc_ready_o <= 1'b0;
               end
            end
            ST_DRAIN: begin
               // final lane has reached the output register this cycle
               if (vld_pipe[STAGES] && last_pipe[STAGES]) begin
                  state  <= ST_IDLE;
                  done_o <= 1'b1;
               end
            end
            default: begin
               state       <= ST_IDLE;
               acc_ready_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_activation_writer.sv
// Scoreboard bench for activation_writer: the driver pushes expected writes
// and done pulses (value + cycle) computed from a plain-arithmetic model;
// a negedge monitor pops and compares whenever the DUT writes or finishes.
module tb_activation_writer;

   localparam int DW  = 7;
   localparam int AW  = 48;
   localparam int BAW = 15;
   localparam int SW  = 6;
   localparam int NLW = BAW + 2;
   localparam int WW  = DW * 4;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           start_i;
   logic [BAW-1:0] base_addr_i;
   logic [NLW-1:0] num_lanes_i;
   logic [SW-1:0]  shift_i;
   logic           acc_valid_i;
   logic           acc_ready_o;
   logic [AW-1:0]  acc_data_i;
   logic           buffer_wr_en_o;
   logic [BAW-1:0] buffer_wr_addr_o;
   logic [WW-1:0]  buffer_data_o;
   logic           busy_o;
   logic           done_o;

   activation_writer #(
      .DATA_WIDTH(DW), .MAC_ACC_WIDTH(AW), .BUFFER_ADDR_WIDTH(BAW), .SHIFT_WIDTH(SW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .base_addr_i(base_addr_i),
      .num_lanes_i(num_lanes_i), .shift_i(shift_i), .acc_valid_i(acc_valid_i),
      .acc_ready_o(acc_ready_o), .acc_data_i(acc_data_i),
      .buffer_wr_en_o(buffer_wr_en_o), .buffer_wr_addr_o(buffer_wr_addr_o),
      .buffer_data_o(buffer_data_o), .busy_o(busy_o), .done_o(done_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [BAW-1:0] addr;
      logic [WW-1:0]  data;
      logic [31:0]    cyc;
   } wr_t;

   wr_t            wq[$];
   int             dq[$];
   longint         vals[$];
   int             cyc = 0;
   int             checks = 0;
   int             failures = 0;
   logic [BAW-1:0] hold_addr;
   logic [WW-1:0]  hold_data;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string nm);
      checks++;
      failures++;
      $display("FAIL %s (cycle %0d)", nm, cyc);
   endtask

   // Reference requantization: round half up, floor-shift, clamp.
   function automatic logic [DW-1:0] ref_q(input longint v, input int s);
      longint t;
      t = v;
      if (s > 0) t = t + (longint'(1) <<< (s - 1));
      t = t >>> s;
      if (t > 63)  t = 63;
      if (t < -64) t = -64;
`ifdef ACT_WRITER_RELU_EN
      if (t < 0) t = 0;
`endif
      return t[DW-1:0];
   endfunction

   function automatic longint rnd_acc(input int sh);
      int     k;
      longint r;
      k = sh + int'($urandom_range(0, 10));
      if (k > 46) k = 46;
      if (k < 1)  k = 1;
      r = longint'({$urandom, $urandom}) & ((longint'(1) <<< k) - 1);
      if ($urandom_range(0, 1) == 1) r = -r;
      return r;
   endfunction

   // Monitor: scoreboard pop on every write / done, hold check otherwise.
   always @(negedge clk) begin
      wr_t e;
      int  dc;
      if (!rst_n) begin
         hold_addr = '0;
         hold_data = '0;
      end else begin
         if (buffer_wr_en_o) begin
            if (wq.size() == 0) fail_now("unexpected_write");
            else begin
               e = wq.pop_front();
               chk("wr_addr",  64'(buffer_wr_addr_o), 64'(e.addr));
               chk("wr_data",  64'(buffer_data_o),    64'(e.data));
               chk("wr_cycle", 64'(cyc),              64'(e.cyc));
               hold_addr = e.addr;
               hold_data = e.data;
            end
         end else begin
            chk("hold_addr", 64'(buffer_wr_addr_o), 64'(hold_addr));
            chk("hold_data", 64'(buffer_data_o),    64'(hold_data));
         end
         if (done_o) begin
            if (dq.size() == 0) fail_now("unexpected_done");
            else begin
               dc = dq.pop_front();
               chk("done_cycle", 64'(cyc), 64'(dc));
            end
            chk("busy_at_done", 64'(busy_o), 64'(1));
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         acc_valid_i = 1'($urandom_range(0, 1));
         acc_data_i  = AW'({$urandom, $urandom});
      end
   endtask

   // Runs one job using the values in vals; glitch pulses start_i mid-run.
   task automatic run_job(input logic [BAW-1:0] base, input int num, input int sh, input bit glitch);
      int             c0, acc_c, t;
      bit             got;
      longint         v;
      logic [WW-1:0]  word;
      logic [BAW-1:0] addr;
      @(posedge clk); #1;
      start_i = 1'b1; base_addr_i = base; num_lanes_i = NLW'(num);
      shift_i = SW'(sh); acc_valid_i = 1'b0;
      c0 = cyc;
      if (num == 0) dq.push_back(c0 + 1);
      @(negedge clk);
      chk("ready_in_idle", 64'(acc_ready_o), 64'(0));
      @(posedge clk); #1;
      start_i = 1'b0;
      base_addr_i = BAW'($urandom);
      num_lanes_i = NLW'($urandom_range(0, 20));
      shift_i = SW'($urandom);
      @(negedge clk);
      chk("busy_after_start", 64'(busy_o), 64'(1));
      if (num == 0) begin
         @(negedge clk);
         chk("busy_after_empty", 64'(busy_o), 64'(0));
         return;
      end
      word = '0;
      addr = base;
      acc_c = c0;
      for (int i = 0; i < num; i++) begin
         t = 0;
         got = 1'b0;
         while (!got && t < 50) begin
            @(posedge clk); #1;
            start_i = glitch && (i == 1);
            if (start_i) begin
               base_addr_i = BAW'($urandom);
               num_lanes_i = NLW'($urandom_range(1, 3));
            end
            if ($urandom_range(0, 3) == 0) begin
               acc_valid_i = 1'b0;
               acc_data_i  = AW'({$urandom, $urandom});
            end else begin
               v = vals[i];
               acc_valid_i = 1'b1;
               acc_data_i  = v[AW-1:0];
            end
            @(negedge clk);
            got = acc_valid_i && acc_ready_o;
            t++;
         end
         if (!got) begin
            fail_now("lane_accept_timeout");
            start_i = 1'b0;
            acc_valid_i = 1'b0;
            return;
         end
         acc_c = cyc;
         word[(i % 4) * DW +: DW] = ref_q(vals[i], sh);
         if ((i % 4) == 3 || i == num - 1) begin
            wq.push_back('{addr: addr, data: word, cyc: 32'(acc_c + 2)});
            addr = addr + 1'b1;
            word = '0;
         end
      end
      dq.push_back(acc_c + 3);
      @(posedge clk); #1;
      acc_valid_i = 1'b0;
      start_i = 1'b0;
      repeat (4) @(negedge clk);
      chk("busy_after_done", 64'(busy_o), 64'(0));
   endtask

   task automatic reset_mid_job();
      int n, t;
      @(posedge clk); #1;
      start_i = 1'b1; base_addr_i = 15'h0100; num_lanes_i = NLW'(4);
      shift_i = '0; acc_valid_i = 1'b0;
      @(posedge clk); #1;
      start_i = 1'b0;
      n = 0;
      t = 0;
      while (n < 2 && t < 20) begin
         acc_valid_i = 1'b1;
         acc_data_i  = AW'(n + 5);
         @(negedge clk);
         if (acc_valid_i && acc_ready_o) n++;
         t++;
         @(posedge clk); #1;
      end
      if (n < 2) fail_now("reset_job_accept_timeout");
      rst_n = 1'b0;
      acc_valid_i = 1'b0;
      #1;
      chk("rst_busy",  64'(busy_o),           64'(0));
      chk("rst_ready", 64'(acc_ready_o),      64'(0));
      chk("rst_wr_en", 64'(buffer_wr_en_o),   64'(0));
      chk("rst_done",  64'(done_o),           64'(0));
      chk("rst_addr",  64'(buffer_wr_addr_o), 64'(0));
      chk("rst_data",  64'(buffer_data_o),    64'(0));
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      idle(8);
      @(negedge clk);
      chk("busy_after_reset", 64'(busy_o), 64'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; start_i = 1'b0; base_addr_i = '0; num_lanes_i = '0;
      shift_i = '0; acc_valid_i = 1'b0; acc_data_i = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("init_busy",  64'(busy_o),           64'(0));
      chk("init_ready", 64'(acc_ready_o),      64'(0));
      chk("init_wr_en", 64'(buffer_wr_en_o),   64'(0));
      chk("init_done",  64'(done_o),           64'(0));
      chk("init_addr",  64'(buffer_wr_addr_o), 64'(0));
      chk("init_data",  64'(buffer_data_o),    64'(0));
      @(posedge clk); #1 rst_n = 1'b1;
      idle(3);

      vals = '{1, 2, 3, -1};
      run_job(15'h0010, 4, 0, 1'b0);

      vals = '{24, 1000, -2000, -24};
      run_job(BAW'($urandom), 4, 4, 1'b0);

      vals = {};
      for (int i = 0; i < 8; i++) vals.push_back(rnd_acc(3));
      run_job(15'h7FFF, 8, 3, 1'b0);

      vals = {};
      for (int i = 0; i < 6; i++) vals.push_back(rnd_acc(2));
      run_job(BAW'($urandom), 6, 2, 1'b0);

      run_job(BAW'($urandom), 0, 0, 1'b0);

      vals = {};
      for (int i = 0; i < 7; i++) vals.push_back(rnd_acc(1));
      run_job(BAW'($urandom), 7, 1, 1'b1);

      reset_mid_job();

      vals = '{100, -100, 7, 8, 9};
      run_job(15'h0200, 5, 2, 1'b0);

      for (int j = 0; j < 10; j++) begin
         int n, s;
         n = int'($urandom_range(1, 13));
         s = int'($urandom_range(0, 20));
         vals = {};
         for (int i = 0; i < n; i++) vals.push_back(rnd_acc(s));
         idle(int'($urandom_range(0, 4)));
         run_job(BAW'($urandom), n, s, 1'b0);
      end

      idle(10);
      acc_valid_i = 1'b0;
      @(negedge clk);
      chk("writes_outstanding", 64'(wq.size()), 64'(0));
      chk("dones_outstanding",  64'(dq.size()), 64'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
